dport_mux_n: RTL and testbench

- Parametrised successor to the two-way TCM/external data-port mux.
- Sits between the core data port and NUM_PORTS downstream data-port targets (TCM, AXI bridge, peripheral ports, ...).
- Routes each request by programmable base/mask regions and tracks outstanding requests, so responses always return to the core in order.
- Requests to unmapped addresses complete through an internal error responder.

---
 rtl/dport_pkg.sv | 28 ++
 rtl/dport_region_decode.sv | 42 ++++
 rtl/dport_mux_n.sv | 187 ++++++++++++++++++
 tb/tb_dport_mux_n.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dport_pkg.sv
// dport_pkg
//   Shared widths and the request-strobe bundle used by the data-port mux
//   and its region decoder.
//
//   DPORT_TAG_W   request/response tag width
//   DPORT_ADDR_W  address width
//   DPORT_DATA_W  read/write data width
//   dport_req_t   one request's strobes (read, byte writes, cache ops)
//   req_present() true when any strobe in the bundle is active
package dport_pkg;

    localparam int DPORT_TAG_W  = 11;
    localparam int DPORT_ADDR_W = 32;
    localparam int DPORT_DATA_W = 32;

    typedef struct packed {
        logic       rd;
        logic [3:0] wr;
        logic       invalidate;
        logic       writeback;
        logic       flush;
    } dport_req_t;

    function automatic logic req_present(input dport_req_t r);
        return r.rd | (|r.wr) | r.invalidate | r.writeback | r.flush;
    endfunction

endpackage

// File: rtl/dport_region_decode.sv
// dport_region_decode
//   Combinational priority base/mask decoder. Port i hits when
//   (addr & mask_i) == base_i; the lowest hitting index wins. With no hit
//   the index is NUM_PORTS (the unmapped pseudo-target).
//
//   addr_i      request address
//   hit_o       one-hot winning port (all zero when unmapped)
//   idx_o       winning port index, NUM_PORTS when unmapped
//   unmapped_o  no region matched
module dport_region_decode
    import dport_pkg::*;
#(
    parameter int                        NUM_PORTS = 2,
    parameter int                        IDX_W     = 2,
    parameter logic [NUM_PORTS*32-1:0]   PORT_BASE = '0,
    parameter logic [NUM_PORTS*32-1:0]   PORT_MASK = '0
) (
    input  logic [DPORT_ADDR_W-1:0] addr_i,
    output logic [NUM_PORTS-1:0]    hit_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    unmapped_o
);

    logic found_w;

    always_comb begin
        hit_o   = '0;
        idx_o   = IDX_W'(NUM_PORTS);
        found_w = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_w &&
                ((addr_i & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32])) begin
                hit_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                found_w  = 1'b1;
            end
        end
    end

    assign unmapped_o = ~found_w;

endmodule

// File: rtl/dport_mux_n.sv
// dport_mux_n
//   Routes core data-port requests to NUM_PORTS targets by base/mask region,
//   keeps responses in order by only letting one target have requests in
//   flight at a time, and answers unmapped addresses with a one-cycle error
//   response.
//
//   clk_i, rst_i             clock, synchronous active-high reset
//   mem_*_i / mem_*_o        core-side request and response
//   mem_t_*_o                per-target request (addr/data/tag/cacheable
//                            broadcast, strobes gated to the chosen target)
//   mem_t_*_i                per-target accept and response
module dport_mux_n
    import dport_pkg::*;
#(
    parameter int                      NUM_PORTS       = 2,
    parameter logic [NUM_PORTS*32-1:0] PORT_BASE       = {32'h80000000, 32'h00000000},
    parameter logic [NUM_PORTS*32-1:0] PORT_MASK       = {32'hF0000000, 32'hF0000000},
    parameter int                      MAX_OUTSTANDING = 4,
    parameter int                      OUTSTANDING_W   = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic [DPORT_ADDR_W-1:0]           mem_addr_i,
    input  logic [DPORT_DATA_W-1:0]           mem_data_wr_i,
    input  logic                              mem_rd_i,
    input  logic [3:0]                        mem_wr_i,
    input  logic                              mem_cacheable_i,
    input  logic [DPORT_TAG_W-1:0]            mem_req_tag_i,
    input  logic                              mem_invalidate_i,
    input  logic                              mem_writeback_i,
    input  logic                              mem_flush_i,
    output logic [DPORT_DATA_W-1:0]           mem_data_rd_o,
    output logic                              mem_accept_o,
    output logic                              mem_ack_o,
    output logic                              mem_error_o,
    output logic [DPORT_TAG_W-1:0]            mem_resp_tag_o,

    output logic [NUM_PORTS*DPORT_ADDR_W-1:0] mem_t_addr_o,
    output logic [NUM_PORTS*DPORT_DATA_W-1:0] mem_t_data_wr_o,
    output logic [NUM_PORTS-1:0]              mem_t_rd_o,
    output logic [NUM_PORTS*4-1:0]            mem_t_wr_o,
    output logic [NUM_PORTS-1:0]              mem_t_cacheable_o,
    output logic [NUM_PORTS*DPORT_TAG_W-1:0]  mem_t_req_tag_o,
    output logic [NUM_PORTS-1:0]              mem_t_invalidate_o,
    output logic [NUM_PORTS-1:0]              mem_t_writeback_o,
    output logic [NUM_PORTS-1:0]              mem_t_flush_o,
    input  logic [NUM_PORTS*DPORT_DATA_W-1:0] mem_t_data_rd_i,
    input  logic [NUM_PORTS-1:0]              mem_t_accept_i,
    input  logic [NUM_PORTS-1:0]              mem_t_ack_i,
    input  logic [NUM_PORTS-1:0]              mem_t_error_i,
    input  logic [NUM_PORTS*DPORT_TAG_W-1:0]  mem_t_resp_tag_i
);

    // One extra index value encodes the internal error responder.
    localparam int                 IDX_W    = $clog2(NUM_PORTS + 1);
    localparam logic [IDX_W-1:0]   UNMAPPED = IDX_W'(NUM_PORTS);
    localparam logic [OUTSTANDING_W-1:0] MAX_OUT = OUTSTANDING_W'(MAX_OUTSTANDING);

    dport_req_t                req_s;
    logic                      req_w;
    logic [NUM_PORTS-1:0]      hit_w;
    logic [IDX_W-1:0]          tgt_w;
    logic                      unmapped_w;

    logic [IDX_W-1:0]          sel_q, sel_d;
    logic [OUTSTANDING_W-1:0]  pending_q, pending_d;
    logic                      err_valid_q, err_valid_d;
    logic [DPORT_TAG_W-1:0]    err_tag_q, err_tag_d;

    logic                      issue_ok_w;
    logic                      accept_w;
    logic                      ack_w;
    logic                      resp_ack_w;
    logic                      resp_err_w;
    logic [DPORT_DATA_W-1:0]   resp_data_w;
    logic [DPORT_TAG_W-1:0]    resp_tag_w;

    assign req_s.rd         = mem_rd_i;
    assign req_s.wr         = mem_wr_i;
    assign req_s.invalidate = mem_invalidate_i;
    assign req_s.writeback  = mem_writeback_i;
    assign req_s.flush      = mem_flush_i;
    assign req_w            = req_present(req_s);

    dport_region_decode #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W),
        .PORT_BASE (PORT_BASE),
        .PORT_MASK (PORT_MASK)
    ) u_decode (
        .addr_i     (mem_addr_i),
        .hit_o      (hit_w),
        .idx_o      (tgt_w),
        .unmapped_o (unmapped_w)
    );

    // Only the registered count is consulted: an ack landing this cycle
    // frees its slot from the next cycle on, keeping the path short.
    assign issue_ok_w = ~rst_i & req_w &
                        ((pending_q == '0) |
                         ((tgt_w == sel_q) & (pending_q < MAX_OUT)));

    assign accept_w     = issue_ok_w & (unmapped_w | (|(hit_w & mem_t_accept_i)));
    assign mem_accept_o = accept_w;

    // Broadcast fields need no gating; targets qualify them with strobes.
    assign mem_t_addr_o      = {NUM_PORTS{mem_addr_i}};
    assign mem_t_data_wr_o   = {NUM_PORTS{mem_data_wr_i}};
    assign mem_t_cacheable_o = {NUM_PORTS{mem_cacheable_i}};
    assign mem_t_req_tag_o   = {NUM_PORTS{mem_req_tag_i}};

    always_comb begin
        mem_t_rd_o         = '0;
        mem_t_wr_o         = '0;
        mem_t_invalidate_o = '0;
        mem_t_writeback_o  = '0;
        mem_t_flush_o      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (issue_ok_w && hit_w[i]) begin
                mem_t_rd_o[i]         = req_s.rd;
                mem_t_wr_o[4*i +: 4]  = req_s.wr;
                mem_t_invalidate_o[i] = req_s.invalidate;
                mem_t_writeback_o[i]  = req_s.writeback;
                mem_t_flush_o[i]      = req_s.flush;
            end
        end
    end

    // Response side listens only to the target that owns the in-flight
    // requests; anything from other ports is dropped.
    always_comb begin
        resp_ack_w  = 1'b0;
        resp_err_w  = 1'b0;
        resp_data_w = '0;
        resp_tag_w  = '0;
        if (sel_q == UNMAPPED) begin
            resp_ack_w = err_valid_q;
            resp_err_w = 1'b1;
            resp_tag_w = err_tag_q;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (sel_q == IDX_W'(i)) begin
                    resp_ack_w  = mem_t_ack_i[i];
                    resp_err_w  = mem_t_error_i[i];
                    resp_data_w = mem_t_data_rd_i[DPORT_DATA_W*i +: DPORT_DATA_W];
                    resp_tag_w  = mem_t_resp_tag_i[DPORT_TAG_W*i +: DPORT_TAG_W];
                end
            end
        end
    end

    // With nothing outstanding any ack is stale (e.g. after a reset) and
    // must neither reach the core nor underflow the counter.
    assign ack_w          = ~rst_i & resp_ack_w & (pending_q != '0);
    assign mem_ack_o      = ack_w;
    assign mem_error_o    = ack_w & resp_err_w;
    assign mem_data_rd_o  = resp_data_w;
    assign mem_resp_tag_o = resp_tag_w;

    always_comb begin
        pending_d = pending_q;
        if (accept_w && !ack_w) begin
            pending_d = pending_q + OUTSTANDING_W'(1);
        end else if (!accept_w && ack_w) begin
            pending_d = pending_q - OUTSTANDING_W'(1);
        end
        sel_d       = accept_w ? tgt_w : sel_q;
        err_valid_d = accept_w & unmapped_w;
        err_tag_d   = (accept_w && unmapped_w) ? mem_req_tag_i : err_tag_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q       <= '0;
            pending_q   <= '0;
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            sel_q       <= sel_d;
            pending_q   <= pending_d;
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
        end
    end

endmodule

// File: tb/tb_dport_mux_n.sv
module tb_dport_mux_n;

    localparam int N    = 2;
    localparam int MAXO = 4;
    localparam logic [N*32-1:0] BASE = {32'h80000000, 32'h00000000};
    localparam logic [N*32-1:0] MASK = {32'hF0000000, 32'hF0000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [31:0]   addr, wdata;
    logic          rd, cach, inv, wb, fl;
    logic [3:0]    wr;
    logic [10:0]   tag;
    logic [31:0]   data_rd;
    logic          accept, ack, error;
    logic [10:0]   resp_tag;

    logic [N*32-1:0] t_addr, t_wdata, t_data;
    logic [N-1:0]    t_rd, t_cach, t_inv, t_wb, t_fl, t_acc, t_ack, t_err;
    logic [N*4-1:0]  t_wr;
    logic [N*11-1:0] t_reqtag, t_rtag;

    dport_mux_n #(
        .NUM_PORTS(N), .PORT_BASE(BASE), .PORT_MASK(MASK),
        .MAX_OUTSTANDING(MAXO), .OUTSTANDING_W(3)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd), .mem_wr_i(wr),
        .mem_cacheable_i(cach), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
        .mem_writeback_i(wb), .mem_flush_i(fl),
        .mem_data_rd_o(data_rd), .mem_accept_o(accept), .mem_ack_o(ack),
        .mem_error_o(error), .mem_resp_tag_o(resp_tag),
        .mem_t_addr_o(t_addr), .mem_t_data_wr_o(t_wdata), .mem_t_rd_o(t_rd),
        .mem_t_wr_o(t_wr), .mem_t_cacheable_o(t_cach), .mem_t_req_tag_o(t_reqtag),
        .mem_t_invalidate_o(t_inv), .mem_t_writeback_o(t_wb), .mem_t_flush_o(t_fl),
        .mem_t_data_rd_i(t_data), .mem_t_accept_i(t_acc), .mem_t_ack_i(t_ack),
        .mem_t_error_i(t_err), .mem_t_resp_tag_i(t_rtag)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: how many requests are owed by which target, and
    // whether an unmapped error reply is due this cycle.
    int          m_pend = 0;
    int          m_sel  = 0;
    bit          m_uflag = 0;
    logic [10:0] m_utag = '0;

    logic        obs_acc, obs_ack, obs_err;
    logic [N-1:0]   obs_rd;
    logic [N*4-1:0] obs_wr;
    logic [31:0] obs_data;
    logic [10:0] obs_tag;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
        return N;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, compare against the model, then advance.
    task automatic step();
        int tgt;
        bit req, ok, e_acc, e_ack, e_err;
        logic [N-1:0]   e_rd, e_inv, e_wb, e_fl;
        logic [N*4-1:0] e_wr;
        logic [31:0]    e_data;
        logic [10:0]    e_tag;
        #4;
        req = rd | (|wr) | inv | wb | fl;
        tgt = decode(addr);
        ok  = !rst && req && (m_pend == 0 || (tgt == m_sel && m_pend < MAXO));
        e_acc = ok && (tgt == N || t_acc[tgt]);
        e_rd = '0; e_wr = '0; e_inv = '0; e_wb = '0; e_fl = '0;
        if (ok && tgt < N) begin
            e_rd[tgt] = rd; e_wr[4*tgt +: 4] = wr;
            e_inv[tgt] = inv; e_wb[tgt] = wb; e_fl[tgt] = fl;
        end
        e_ack = 0; e_err = 0; e_data = '0; e_tag = '0;
        if (!rst && m_pend > 0) begin
            if (m_sel == N) begin
                e_ack = m_uflag; e_err = m_uflag; e_tag = m_utag;
            end else begin
                e_ack  = t_ack[m_sel];
                e_err  = t_ack[m_sel] & t_err[m_sel];
                e_data = t_data[32*m_sel +: 32];
                e_tag  = t_rtag[11*m_sel +: 11];
            end
        end
        obs_acc = accept; obs_ack = ack; obs_err = error;
        obs_rd = t_rd; obs_wr = t_wr; obs_data = data_rd; obs_tag = resp_tag;
        chk("accept", 64'(accept), 64'(e_acc));
        chk("ack", 64'(ack), 64'(e_ack));
        chk("error", 64'(error), 64'(e_err));
        chk("t_rd", 64'(t_rd), 64'(e_rd));
        chk("t_wr", 64'(t_wr), 64'(e_wr));
        chk("t_cacheops", 64'({t_inv, t_wb, t_fl}), 64'({e_inv, e_wb, e_fl}));
        if (e_ack) begin
            chk("resp_data", 64'(data_rd), 64'(e_data));
            chk("resp_tag", 64'(resp_tag), 64'(e_tag));
        end
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_sel = 0; m_uflag = 0;
        end else begin
            m_pend  = m_pend + int'(e_acc) - int'(e_ack);
            m_uflag = e_acc && tgt == N;
            if (e_acc) m_sel = tgt;
            if (e_acc && tgt == N) m_utag = tag;
        end
        #1;
    endtask

    task automatic idle();
        rd = 0; wr = '0; inv = 0; wb = 0; fl = 0;
    endtask

    task automatic rdreq(input logic [31:0] a, input logic [10:0] tg);
        idle(); rd = 1; addr = a; tag = tg;
    endtask

    initial begin
        logic [31:0] r;
        int op, region;
        rst = 1; addr = '0; wdata = '0; cach = 0; tag = '0; idle();
        t_data = '0; t_acc = '0; t_ack = '0; t_err = '0; t_rtag = '0;
        @(posedge clk); #1;

        // Reset: request present, everything still held off.
        rdreq(32'h0000_0100, 11'h01); t_acc = 2'b11;
        step(); chk("rst_accept", 64'(obs_acc), 64'd0);
        step();
        rst = 0; idle();
        step();

        // Port0 read, ack two cycles later.
        rdreq(32'h0000_0100, 11'h05);
        step(); chk("t1_acc", 64'(obs_acc), 64'd1); chk("t1_rd", 64'(obs_rd), 64'b01);
        idle(); step();
        t_ack = 2'b01; t_data = {32'h0, 32'hDEADBEEF}; t_rtag = {11'h0, 11'h05};
        step();
        chk("t1_ack", 64'(obs_ack), 64'd1); chk("t1_data", 64'(obs_data), 64'hDEADBEEF);
        chk("t1_tag", 64'(obs_tag), 64'h05); chk("t1_err", 64'(obs_err), 64'd0);
        t_ack = '0;

        // Four reads to port1 fill it; the fifth waits for an ack.
        for (int k = 0; k < 4; k++) begin
            rdreq(32'h8000_0000 + 32'(4*k), 11'(k));
            step(); chk("t2_acc", 64'(obs_acc), 64'd1);
        end
        rdreq(32'h8000_0010, 11'h10);
        step(); chk("t2_stall", 64'(obs_acc), 64'd0); chk("t2_stall_rd", 64'(obs_rd), 64'b00);
        t_ack = 2'b10;
        step(); chk("t2_ack_same", 64'(obs_acc), 64'd0);
        t_ack = '0;
        step(); chk("t2_issue", 64'(obs_acc), 64'd1);
        idle(); t_ack = 2'b10;
        for (int k = 0; k < 4; k++) step();
        t_ack = '0;

        // Target switch: write to port1 waits for port0 to drain.
        rdreq(32'h0000_0200, 11'h07); step();
        idle(); wr = 4'hF; addr = 32'h8000_0010; wdata = 32'h1234_5678;
        step(); chk("t3_hold", 64'(obs_acc), 64'd0);
        t_ack = 2'b01;
        step(); chk("t3_hold_ack", 64'(obs_acc), 64'd0);
        t_ack = '0;
        step(); chk("t3_issue", 64'(obs_acc), 64'd1); chk("t3_wr", 64'(obs_wr), 64'hF0);
        idle(); t_ack = 2'b10; step(); t_ack = '0;

        // Unmapped read gets an error reply one cycle later.
        rdreq(32'h4000_0000, 11'h3A);
        step(); chk("t4_acc", 64'(obs_acc), 64'd1); chk("t4_rd", 64'(obs_rd), 64'b00);
        idle(); step();
        chk("t4_ack", 64'(obs_ack), 64'd1); chk("t4_err", 64'(obs_err), 64'd1);
        chk("t4_data", 64'(obs_data), 64'd0); chk("t4_tag", 64'(obs_tag), 64'h3A);

        // Accept and ack together on port0 leave pending at 2.
        rdreq(32'h0000_0000, 11'h11); step(); step();
        t_ack = 2'b01; step(); chk("t5_both", 64'({obs_acc, obs_ack}), 64'b11);
        idle(); step(); step();
        step(); chk("t5_drained", 64'(obs_ack), 64'd0);
        t_ack = '0;
        rdreq(32'h0000_0040, 11'h12); step(); idle();
        t_ack = 2'b10; step(); chk("t5_spurious", 64'(obs_ack), 64'd0);
        t_ack = 2'b01; step(); t_ack = '0;

        // Reset with three in flight, then stale acks.
        rdreq(32'h0000_0000, 11'h20); step(); step(); step();
        idle(); rst = 1; step(); rst = 0;
        t_ack = 2'b01; step(); chk("t6_stale", 64'(obs_ack), 64'd0);
        step(); chk("t6_stale2", 64'(obs_ack), 64'd0);
        t_ack = '0;
        rdreq(32'h8000_0000, 11'h21); step(); chk("t6_issue", 64'(obs_acc), 64'd1);
        idle(); t_ack = 2'b10; step(); t_ack = '0;

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            idle();
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: rd = 1;
                4, 5:       wr = 4'($urandom_range(1, 15));
                6:          inv = 1;
                7:          wb = 1;
                8:          fl = 1;
                default:    ;
            endcase
            r = $urandom();
            region = $urandom_range(0, 2);
            addr  = (region == 0) ? {4'h0, r[27:0]} :
                    (region == 1) ? {4'h8, r[27:0]} : {4'h4, r[27:0]};
            wdata = $urandom();
            tag   = 11'($urandom());
            cach  = 1'($urandom());
            t_acc = 2'($urandom_range(0, 3));
            t_ack = 2'($urandom_range(0, 3));
            t_err = 2'($urandom_range(0, 3));
            t_data = {$urandom(), $urandom()};
            t_rtag = 22'($urandom());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
